// File: rtl/riscv_crypto_fu_ssm3_pipe_pkg.sv
// rtl/riscv_crypto_fu_ssm3_pipe_pkg.sv - shared constants and helpers for the SM3 permutation unit
// Contents: rotation constants, rol32, the two halves of P0/P1 and parameter legality checks.
package riscv_crypto_fu_ssm3_pipe_pkg;

    localparam int unsigned SSM3_P0_R1 = 9;
    localparam int unsigned SSM3_P0_R2 = 17;
    localparam int unsigned SSM3_P1_R1 = 15;
    localparam int unsigned SSM3_P1_R2 = 23;

    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned sh);
        return (x << sh) | (x >> (32 - sh));
    endfunction

    // First half of the permutation: x ^ rol(x, R1) for each selected op.
    // With both ops selected the two x terms cancel, which the tail relies on.
    function automatic logic [31:0] ssm3_partial(input logic [31:0] x, input logic p0, input logic p1);
        return ({32{p0}} & (x ^ rol32(x, SSM3_P0_R1))) ^
               ({32{p1}} & (x ^ rol32(x, SSM3_P1_R1)));
    endfunction

    // Second half: the R2 rotation terms; final = partial ^ tail.
    function automatic logic [31:0] ssm3_tail(input logic [31:0] x, input logic p0, input logic p1);
        return ({32{p0}} & rol32(x, SSM3_P0_R2)) ^
               ({32{p1}} & rol32(x, SSM3_P1_R2));
    endfunction

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit stages_legal(input int stages);
        return (stages >= 0) && (stages <= 2);
    endfunction

endpackage

// File: rtl/riscv_crypto_fu_ssm3_pipe_if.sv
// rtl/riscv_crypto_fu_ssm3_pipe_if.sv - request/result handshake bundle of the SM3 permutation unit
// master: issue/writeback side (drives flush, valid, rs1, op selects, rd_ready).
// slave:  the functional unit (drives ready, rd_valid, rd).
interface riscv_crypto_fu_ssm3_pipe_if #(
    parameter int XLEN = 64
) ();
    logic            flush;
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] rs1;
    logic            op_ssm3_p0;
    logic            op_ssm3_p1;
    logic            op_packed;
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd;

    modport master (
        output flush, valid, rs1, op_ssm3_p0, op_ssm3_p1, op_packed, rd_ready,
        input  ready, rd_valid, rd
    );

    modport slave (
        input  flush, valid, rs1, op_ssm3_p0, op_ssm3_p1, op_packed, rd_ready,
        output ready, rd_valid, rd
    );
endinterface

// File: rtl/riscv_crypto_fu_ssm3_lane.sv
// rtl/riscv_crypto_fu_ssm3_lane.sv - one combinational 32-bit SM3 P0/P1 lane
// Ports: x_a/p0_a/p1_a produce the partial t; x_b/p0_b/p1_b/t_in produce result = t_in ^ tail(x_b).
// Unpipelined use ties the b side to the a side and t_in to t; the two-stage pipe feeds
// the b side from its stage-A registers so one instance covers both halves.
module riscv_crypto_fu_ssm3_lane
    import riscv_crypto_fu_ssm3_pipe_pkg::*;
(
    input  logic [31:0] x_a,
    input  logic        p0_a,
    input  logic        p1_a,
    input  logic [31:0] x_b,
    input  logic        p0_b,
    input  logic        p1_b,
    input  logic [31:0] t_in,
    output logic [31:0] t,
    output logic [31:0] result
);
    assign t      = ssm3_partial(x_a, p0_a, p1_a);
    assign result = t_in ^ ssm3_tail(x_b, p0_b, p1_b);
endmodule

// File: rtl/riscv_crypto_fu_ssm3_pipe.sv
// rtl/riscv_crypto_fu_ssm3_pipe.sv - pipelined ssm3.p0/ssm3.p1 functional unit with valid/ready handshake
// Ports: g_clk, g_resetn (async active-low), io (slave modport: flush, valid/ready, rs1,
// op selects, op_packed, rd_valid/rd_ready, rd). STAGES selects 0, 1 or 2 register stages.
module riscv_crypto_fu_ssm3_pipe
    import riscv_crypto_fu_ssm3_pipe_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int STAGES    = 1,
    parameter bit PACKED_EN = 1'b1
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    riscv_crypto_fu_ssm3_pipe_if.slave   io
);
    localparam int NLANES = (XLEN == 64) ? 2 : 1;
    localparam bit PK     = (XLEN == 64) && PACKED_EN;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("riscv_crypto_fu_ssm3_pipe: XLEN must be 32 or 64");
    end
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("riscv_crypto_fu_ssm3_pipe: STAGES must be 0, 1 or 2");
    end

    logic            in_pk;
    logic            out_can;       // output side can take a result this cycle
    logic            out_src_vld;   // a result is offered to the output side
    logic [XLEN-1:0] lane_x_b, lane_t_in, lane_t, lane_res;
    logic            lane_p0_b, lane_p1_b, lane_pk_b;

    assign in_pk = PK && io.op_packed;

    // Lane 1 has its op selects masked when not packed, so it yields 0 (zero-extension).
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic gate_a, gate_b;
        assign gate_a = (i == 0) || in_pk;
        assign gate_b = (i == 0) || lane_pk_b;
        riscv_crypto_fu_ssm3_lane u_lane (
            .x_a    (io.rs1[32*i +: 32]),
            .p0_a   (io.op_ssm3_p0 & gate_a),
            .p1_a   (io.op_ssm3_p1 & gate_a),
            .x_b    (lane_x_b[32*i +: 32]),
            .p0_b   (lane_p0_b & gate_b),
            .p1_b   (lane_p1_b & gate_b),
            .t_in   (lane_t_in[32*i +: 32]),
            .t      (lane_t[32*i +: 32]),
            .result (lane_res[32*i +: 32])
        );
    end

    if (STAGES == 2) begin : g_stage_a
        logic            a_vld_q, a_vld_d, a_load;
        logic [XLEN-1:0] a_x_q, a_x_d, a_t_q, a_t_d;
        logic            a_p0_q, a_p0_d, a_p1_q, a_p1_d, a_pk_q, a_pk_d;

        assign io.ready    = !io.flush && (!a_vld_q || out_can);
        assign out_src_vld = a_vld_q;

        always_comb begin
            a_load  = io.valid && io.ready;
            a_vld_d = a_vld_q;
            a_x_d   = a_x_q;
            a_t_d   = a_t_q;
            a_p0_d  = a_p0_q;
            a_p1_d  = a_p1_q;
            a_pk_d  = a_pk_q;
            if (io.flush) begin
                a_vld_d = 1'b0;
            end else if (!a_vld_q || out_can) begin
                a_vld_d = io.valid;
            end
            if (a_load) begin
                a_x_d  = io.rs1;
                a_t_d  = lane_t;
                a_p0_d = io.op_ssm3_p0;
                a_p1_d = io.op_ssm3_p1;
                a_pk_d = in_pk;
            end
        end

        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                a_vld_q <= 1'b0;
                a_x_q   <= '0;
                a_t_q   <= '0;
                a_p0_q  <= 1'b0;
                a_p1_q  <= 1'b0;
                a_pk_q  <= 1'b0;
            end else begin
                a_vld_q <= a_vld_d;
                a_x_q   <= a_x_d;
                a_t_q   <= a_t_d;
                a_p0_q  <= a_p0_d;
                a_p1_q  <= a_p1_d;
                a_pk_q  <= a_pk_d;
            end
        end

        assign lane_x_b  = a_x_q;
        assign lane_p0_b = a_p0_q;
        assign lane_p1_b = a_p1_q;
        assign lane_pk_b = a_pk_q;
        assign lane_t_in = a_t_q;
    end else begin : g_stage_direct
        assign lane_x_b  = io.rs1;
        assign lane_p0_b = io.op_ssm3_p0;
        assign lane_p1_b = io.op_ssm3_p1;
        assign lane_pk_b = in_pk;
        assign lane_t_in = lane_t;
        if (STAGES == 1) begin : g_in_reg
            assign io.ready    = !io.flush && out_can;
            assign out_src_vld = io.valid && io.ready;
        end else begin : g_in_comb
            assign io.ready    = out_can;
            assign out_src_vld = io.valid;
        end
    end

    if (STAGES == 0) begin : g_out_comb
        assign out_can     = io.rd_ready;
        assign io.rd_valid = out_src_vld;
        assign io.rd       = lane_res;
    end else begin : g_out_reg
        logic            b_vld_q, b_vld_d, b_load;
        logic [XLEN-1:0] b_rd_q, b_rd_d;

        assign out_can = !b_vld_q || io.rd_ready;

        always_comb begin
            b_load  = !io.flush && out_can && out_src_vld;
            b_vld_d = b_vld_q;
            b_rd_d  = b_rd_q;
            if (io.flush) begin
                b_vld_d = 1'b0;
            end else if (out_can) begin
                b_vld_d = out_src_vld;
            end
            if (b_load) begin
                b_rd_d = lane_res;
            end
        end

        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                b_vld_q <= 1'b0;
                b_rd_q  <= '0;
            end else begin
                b_vld_q <= b_vld_d;
                b_rd_q  <= b_rd_d;
            end
        end

        assign io.rd_valid = b_vld_q;
        assign io.rd       = b_rd_q;
    end

endmodule
